// File: rtl/ula_pkg.sv
// Shared definitions for the ALU arbiter slice: op codes, sequencer states
// and the op-to-select mapping driven onto the Ula4bits X2/X1/X0 inputs.
package ula_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SLT = 2'b10,
        OP_BEQ = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    // {X2,X1,X0}; BEQ shares the compare path with SLT and reads the igual flag
    localparam logic [2:0] SEL_ADD = 3'b000;
    localparam logic [2:0] SEL_SUB = 3'b001;
    localparam logic [2:0] SEL_SLT = 3'b111;
    localparam logic [2:0] SEL_BEQ = 3'b111;

endpackage

// File: rtl/ula_arbiter_if.sv
// Requester-side bundle of the ALU arbiter: two request/operand channels
// plus the shared grant/done/result return path.
interface ula_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0, req1;
    logic [1:0]       op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             gnt0, gnt1;
    logic             done0, done1;
    logic [WIDTH-1:0] res_f;
    logic             res_menor, res_igual;
    logic             busy;

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1,
        input  gnt0, gnt1, done0, done1, res_f, res_menor, res_igual, busy
    );

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1,
        output gnt0, gnt1, done0, done1, res_f, res_menor, res_igual, busy
    );
endinterface

// File: rtl/ula_op_decode.sv
// Combinational op-code to ALU select decoder ({X2,X1,X0}).
module ula_op_decode
    import ula_pkg::*;
(
    input  logic [1:0] op,
    output logic [2:0] sel
);
    always_comb begin
        sel = SEL_ADD;
        case (op_t'(op))
            OP_ADD:  sel = SEL_ADD;
            OP_SUB:  sel = SEL_SUB;
            OP_SLT:  sel = SEL_SLT;
            OP_BEQ:  sel = SEL_BEQ;
            default: sel = SEL_ADD;
        endcase
    end
endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter/sequencer sharing one Ula4bits between the execute
// stage (requester 0) and the branch/compare unit (requester 1).
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    ula_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic             ula_x0,
    output logic             ula_x1,
    output logic             ula_x2,
    input  logic [WIDTH-1:0] ula_f,
    input  logic [WIDTH-1:0] ula_menor,
    input  logic [WIDTH-1:0] ula_igual
);
    state_t           state, next_state;
    logic             ptr;
    logic             owner;
    logic             grant;
    logic             win;
    logic [1:0]       win_op;
    logic [2:0]       win_sel;
    logic [2:0]       sel_q;
    logic [WIDTH-1:0] res_f_q;
    logic             res_menor_q, res_igual_q;
    logic             unused_flag_bits;

    assign unused_flag_bits = ^{ula_menor[WIDTH-1:1], ula_igual[WIDTH-1:1]};

    ula_op_decode u_dec (
        .op  (win_op),
        .sel (win_sel)
    );

    always_comb begin
        next_state = state;
        grant      = 1'b0;
        win        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant      = 1'b1;
                    // Contention goes to the pointer; otherwise the lone requester wins
                    win        = (bus.req0 && bus.req1) ? ptr : bus.req1;
                    next_state = EXEC;
                end
            end
            EXEC:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        win_op = win ? bus.op1 : bus.op0;
    end

    always_comb begin
        bus.gnt0      = (state == EXEC) && !owner;
        bus.gnt1      = (state == EXEC) &&  owner;
        bus.done0     = (state == DONE) && !owner;
        bus.done1     = (state == DONE) &&  owner;
        bus.busy      = (state != IDLE);
        bus.res_f     = res_f_q;
        bus.res_menor = res_menor_q;
        bus.res_igual = res_igual_q;
        ula_x2        = sel_q[2];
        ula_x1        = sel_q[1];
        ula_x0        = sel_q[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            ula_a       <= '0;
            ula_b       <= '0;
            sel_q       <= '0;
            res_f_q     <= '0;
            res_menor_q <= 1'b0;
            res_igual_q <= 1'b0;
        end else begin
            state <= next_state;
            if (grant) begin
                owner <= win;
                ptr   <= ~win;
                ula_a <= win ? bus.a1 : bus.a0;
                ula_b <= win ? bus.b1 : bus.b0;
                sel_q <= win_sel;
            end
            if (state == EXEC) begin
                res_f_q     <= ula_f;
                res_menor_q <= ula_menor[0];
                res_igual_q <= ula_igual[0];
            end
        end
    end
endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter with a small behavioural Ula4bits stand-in.
module tb_ula_arbiter;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] ula_a, ula_b, ula_f, ula_menor, ula_igual;
    logic         ula_x0, ula_x1, ula_x2;
    int           total = 0;
    int           bad = 0;

    ula_arbiter_if #(.WIDTH(W)) bus ();

    ula_arbiter #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ula_a     (ula_a),
        .ula_b     (ula_b),
        .ula_x0    (ula_x0),
        .ula_x1    (ula_x1),
        .ula_x2    (ula_x2),
        .ula_f     (ula_f),
        .ula_menor (ula_menor),
        .ula_igual (ula_igual)
    );

    always #5 clk = ~clk;

    // ALU stand-in; upper flag bits are junk so only bit 0 may matter
    always_comb begin
        ula_f     = ula_a + ula_b;
        ula_menor = {3'b101, (ula_a < ula_b)};
        ula_igual = {3'b110, (ula_a == ula_b)};
        case ({ula_x2, ula_x1, ula_x0})
            3'b000:  ula_f = ula_a + ula_b;
            3'b001:  ula_f = ula_a - ula_b;
            default: ula_f = ula_a - ula_b;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.op0 = 2'b00; bus.op1 = 2'b00;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b00000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy});
        end
        total++;
        if ({ula_a, ula_b, ula_x2, ula_x1, ula_x0, bus.res_f, bus.res_menor, bus.res_igual} !== 17'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", {ula_a, ula_b, ula_x2, ula_x1, ula_x0, bus.res_f, bus.res_menor, bus.res_igual});
        end
        reset = 1'b0;
        // start an ADD, then abort it in EXEC
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 4'b0101; bus.b0 = 4'b0011;
        tick();
        total++;
        if (bus.gnt0 !== 1'b1) begin
            bad++;
            $display("FAIL abort_gnt0 got=%b want=1", bus.gnt0);
        end
        bus.req0 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.gnt0, ula_a, ula_x2, ula_x1, ula_x0, bus.res_f} !== 14'h0) begin
            bad++;
            $display("FAIL abort_async got=%h want=0", {bus.busy, bus.gnt0, ula_a, ula_x2, ula_x1, ula_x0, bus.res_f});
        end
        tick();
        total++;
        if ({bus.done0, bus.done1} !== 2'b00) begin
            bad++;
            $display("FAIL abort_nodone got=%b want=00", {bus.done0, bus.done1});
        end
        reset = 1'b0;
        // both request: reset pointer must favour requester 0
        bus.req0 = 1'b1; bus.op0 = 2'b01; bus.a0 = 4'b0111; bus.b0 = 4'b0100;
        bus.req1 = 1'b1; bus.op1 = 2'b00; bus.a1 = 4'b0001; bus.b1 = 4'b0001;
        tick();
        total++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset_gnt got=%b want=10", {bus.gnt0, bus.gnt1});
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        total++;
        if ({bus.done0, bus.res_f} !== {1'b1, 4'b0011}) begin
            bad++;
            $display("FAIL post_reset_sub got=%b want=10011", {bus.done0, bus.res_f});
        end
        tick();
    endtask

    task automatic test_add_wrap();
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 4'b1111; bus.b0 = 4'b0010;
        tick();
        total++;
        if ({bus.gnt0, ula_x2, ula_x1, ula_x0, ula_a, ula_b} !== {1'b1, 3'b000, 4'b1111, 4'b0010}) begin
            bad++;
            $display("FAIL add_exec got=%b want=100011110010", {bus.gnt0, ula_x2, ula_x1, ula_x0, ula_a, ula_b});
        end
        bus.req0 = 1'b0;
        tick();
        total++;
        if ({bus.done0, bus.done1, bus.res_f} !== {2'b10, 4'b0001}) begin
            bad++;
            $display("FAIL add_wrap got=%b want=100001", {bus.done0, bus.done1, bus.res_f});
        end
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL add_idle_busy got=%b want=0", bus.busy);
        end
    endtask

    task automatic test_beq();
        bus.req1 = 1'b1; bus.op1 = 2'b11; bus.a1 = 4'b0111; bus.b1 = 4'b0111;
        tick();
        total++;
        if ({bus.gnt1, bus.gnt0, ula_x2, ula_x1, ula_x0} !== 5'b10111) begin
            bad++;
            $display("FAIL beq_exec got=%b want=10111", {bus.gnt1, bus.gnt0, ula_x2, ula_x1, ula_x0});
        end
        bus.req1 = 1'b0;
        tick();
        total++;
        if ({bus.done1, bus.done0, bus.res_igual} !== 3'b101) begin
            bad++;
            $display("FAIL beq_equal got=%b want=101", {bus.done1, bus.done0, bus.res_igual});
        end
        tick();
        bus.req1 = 1'b1; bus.b1 = 4'b0110;
        tick();
        bus.req1 = 1'b0;
        tick();
        total++;
        if ({bus.done1, bus.res_igual} !== 2'b10) begin
            bad++;
            $display("FAIL beq_noteq got=%b want=10", {bus.done1, bus.res_igual});
        end
        tick();
    endtask

    task automatic test_slt();
        bus.req1 = 1'b1; bus.op1 = 2'b10; bus.a1 = 4'b0011; bus.b1 = 4'b0101;
        tick();
        total++;
        if ({bus.gnt1, ula_x2, ula_x1, ula_x0} !== 4'b1111) begin
            bad++;
            $display("FAIL slt_exec got=%b want=1111", {bus.gnt1, ula_x2, ula_x1, ula_x0});
        end
        bus.req1 = 1'b0;
        tick();
        total++;
        if ({bus.done1, bus.res_menor} !== 2'b11) begin
            bad++;
            $display("FAIL slt_menor got=%b want=11", {bus.done1, bus.res_menor});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_ctl [1:9];
        logic [3:0] exp_res [1:9];
        // {gnt0,gnt1,done0,done1} per cycle after each edge
        exp_ctl = '{4'b1000, 4'b0010, 4'b0000, 4'b0100, 4'b0001, 4'b0000, 4'b1000, 4'b0010, 4'b0000};
        exp_res = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010};
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 4'b0001; bus.b0 = 4'b0001;
        bus.req1 = 1'b1; bus.op1 = 2'b01; bus.a1 = 4'b0101; bus.b1 = 4'b0001;
        for (int i = 1; i <= 9; i++) begin
            tick();
            total++;
            if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== exp_ctl[i]) begin
                bad++;
                $display("FAIL rr_ctl cycle=%0d got=%b want=%b", i, {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, exp_ctl[i]);
            end
            if (i >= 2) begin
                total++;
                if (bus.res_f !== exp_res[i]) begin
                    bad++;
                    $display("FAIL rr_res cycle=%0d got=%b want=%b", i, bus.res_f, exp_res[i]);
                end
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    task automatic test_late_request();
        bus.req0 = 1'b1; bus.op0 = 2'b00; bus.a0 = 4'b0011; bus.b0 = 4'b0100;
        tick();
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.op1 = 2'b01; bus.a1 = 4'b1000; bus.b1 = 4'b0011;
        total++;
        if ({bus.gnt0, bus.busy} !== 2'b11) begin
            bad++;
            $display("FAIL late_exec got=%b want=11", {bus.gnt0, bus.busy});
        end
        tick();
        total++;
        if ({bus.done0, bus.gnt1, bus.busy, bus.res_f} !== {3'b101, 4'b0111}) begin
            bad++;
            $display("FAIL late_done0 got=%b want=1010111", {bus.done0, bus.gnt1, bus.busy, bus.res_f});
        end
        tick();
        total++;
        if ({bus.busy, bus.gnt1, bus.res_f} !== {2'b00, 4'b0111}) begin
            bad++;
            $display("FAIL late_idle got=%b want=000111", {bus.busy, bus.gnt1, bus.res_f});
        end
        tick();
        total++;
        if ({bus.gnt1, bus.gnt0, bus.res_f} !== {2'b10, 4'b0111}) begin
            bad++;
            $display("FAIL late_gnt1 got=%b want=100111", {bus.gnt1, bus.gnt0, bus.res_f});
        end
        bus.req1 = 1'b0;
        tick();
        total++;
        if ({bus.done1, bus.done0, bus.res_f} !== {2'b10, 4'b0101}) begin
            bad++;
            $display("FAIL late_done1 got=%b want=100101", {bus.done1, bus.done0, bus.res_f});
        end
        tick();
        total++;
        if ({bus.busy, ula_a, ula_b, ula_x2, ula_x1, ula_x0} !== {1'b0, 4'b1000, 4'b0011, 3'b001}) begin
            bad++;
            $display("FAIL late_hold got=%b want=010000011001", {bus.busy, ula_a, ula_b, ula_x2, ula_x1, ula_x0});
        end
    endtask

    initial begin
        test_reset();
        test_add_wrap();
        test_beq();
        test_slt();
        test_back_to_back();
        test_late_request();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
